// File: rtl/mips_multicycle_ctrl_pkg.sv
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared constants for the multicycle MIPS main controller:
//               4-bit state encoding, opcode values, ALU-op codes, fault
//               codes and a helper that flags memory-access states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t FETCH  = 4'd0;
  localparam state_t DECODE = 4'd1;
  localparam state_t MEMADR = 4'd2;
  localparam state_t MEMRD  = 4'd3;
  localparam state_t MEMWR  = 4'd4;
  localparam state_t MEMWB  = 4'd5;
  localparam state_t EXEC   = 4'd6;
  localparam state_t ALUWB  = 4'd7;
  localparam state_t BRANCH = 4'd8;
  localparam state_t JUMP   = 4'd9;
  localparam state_t IMMEX  = 4'd10;
  localparam state_t IMMWB  = 4'd11;
  localparam state_t ERR    = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // States that own the shared memory port and may stall on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_ctrl_mem_wait_timer.sv
// ============================================================================
// Module      : mem_wait_timer
// Description : Counts stalled cycles of a memory access and flags expiry.
//   clk     in  rising-edge clock
//   rst_n   in  async active-low reset
//   clr     in  return the count to zero
//   busy    in  a memory access is pending this cycle (mem_ready low)
//   expired out pending access has already waited MEM_TIMEOUT cycles
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic busy,
  output logic expired
);

  logic [7:0] r_wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 8'd0;
    end else if (clr) begin
      r_wait_cnt <= 8'd0;
    end else if (busy) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Expiry needs the access to still be pending, so a completion in the
  // same cycle always wins over the timeout.
  assign expired = busy && (r_wait_cnt == 8'(MEM_TIMEOUT));

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Multicycle MIPS main controller. Moore FSM decoded from the
//               state register; pc_wr/ir_wr in FETCH and instr_done in MEMWR
//               are additionally qualified by mem_ready.
//   Inputs : clk, rst_n (async, active low), op[5:0], zero, mem_ready
//   Outputs: pc_wr, pc_wr_cond, iord, mem_rd, mem_wr, ir_wr, mem2reg,
//            reg_dst, reg_wr, wb_byte, alu_src_a, alu_src_b[1:0], zext_imm,
//            alu_op[ALUOP_W-1:0], pc_src[1:0], fault, fault_code[1:0],
//            instr_done
//   Optional: MC_CTRL_PERF_EN adds cyc_cnt/ret_cnt[PERF_W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int PERF_W      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_wr,
  output logic               pc_wr_cond,
  output logic               iord,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               ir_wr,
  output logic               mem2reg,
  output logic               reg_dst,
  output logic               reg_wr,
  output logic               wb_byte,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               zext_imm,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_src,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic               instr_done
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]  cyc_cnt,
  output logic [PERF_W-1:0]  ret_cnt
`endif
);

  logic       r_run;
  state_t     r_state;
  logic       r_fault;
  logic [1:0] r_fault_code;
  logic       w_busy;
  logic       w_expired;
  logic [1:0] w_alu_code;

  // The branch decision is made in the datapath (pc_wr_cond & zero).
  logic w_unused_zero;
  assign w_unused_zero = zero;

  assign w_busy = r_run && is_mem_state(r_state) && !mem_ready;

  // A memory state is only left on completion or timeout, and every other
  // state holds the count at zero, so clearing whenever not stalled is the
  // same as clearing on each state change.
  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!w_busy),
    .busy    (w_busy),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run        <= 1'b0;
      r_state      <= FETCH;
      r_fault      <= 1'b0;
      r_fault_code <= FAULT_NONE;
    end else if (!r_run) begin
      r_run <= 1'b1;
    end else if (w_expired) begin
      r_state      <= ERR;
      r_fault      <= 1'b1;
      r_fault_code <= FAULT_TIMEOUT;
    end else begin
      case (r_state)
        FETCH:   if (mem_ready) r_state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_LB, OP_SW: r_state <= MEMADR;
            OP_RTYPE:            r_state <= EXEC;
            OP_BEQ:              r_state <= BRANCH;
            OP_J:                r_state <= JUMP;
            OP_ADDI, OP_ORI:     r_state <= IMMEX;
            default: begin
              r_state      <= ERR;
              r_fault      <= 1'b1;
              r_fault_code <= FAULT_ILLEGAL;
            end
          endcase
        end
        MEMADR:  r_state <= (op == OP_SW) ? MEMWR : MEMRD;
        MEMRD:   if (mem_ready) r_state <= MEMWB;
        MEMWR:   if (mem_ready) r_state <= FETCH;
        EXEC:    r_state <= ALUWB;
        IMMEX:   r_state <= IMMWB;
        MEMWB, ALUWB, BRANCH, JUMP, IMMWB: r_state <= FETCH;
        ERR:     r_state <= ERR;
        default: r_state <= FETCH;
      endcase
    end
  end

  // Output decode; forced to zero while not running so an asserted reset
  // silences every strobe immediately.
  always_comb begin
    pc_wr      = 1'b0;
    pc_wr_cond = 1'b0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    mem2reg    = 1'b0;
    reg_dst    = 1'b0;
    reg_wr     = 1'b0;
    wb_byte    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    zext_imm   = 1'b0;
    w_alu_code = ALU_ADD;
    pc_src     = 2'd0;
    fault      = 1'b0;
    fault_code = FAULT_NONE;
    instr_done = 1'b0;
    if (r_run) begin
      fault      = r_fault;
      fault_code = r_fault_code;
      case (r_state)
        FETCH: begin
          mem_rd    = 1'b1;
          alu_src_b = 2'd1;
          ir_wr     = mem_ready;
          pc_wr     = mem_ready;
        end
        DECODE: alu_src_b = 2'd3;
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        MEMRD: begin
          mem_rd = 1'b1;
          iord   = 1'b1;
        end
        MEMWR: begin
          mem_wr     = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        MEMWB: begin
          reg_wr     = 1'b1;
          mem2reg    = 1'b1;
          wb_byte    = (op == OP_LB);
          instr_done = 1'b1;
        end
        EXEC: begin
          alu_src_a  = 1'b1;
          w_alu_code = ALU_FUNCT;
        end
        ALUWB: begin
          reg_wr     = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          w_alu_code = ALU_SUB;
          pc_wr_cond = 1'b1;
          pc_src     = 2'd1;
          instr_done = 1'b1;
        end
        JUMP: begin
          pc_wr      = 1'b1;
          pc_src     = 2'd2;
          instr_done = 1'b1;
        end
        IMMEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          if (op == OP_ORI) begin
            w_alu_code = ALU_OR;
            zext_imm   = 1'b1;
          end
        end
        IMMWB: begin
          reg_wr     = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Zero-extends the 2-bit code when ALUOP_W is wider.
  assign alu_op = ALUOP_W'(w_alu_code);

`ifdef MC_CTRL_PERF_EN
  logic [PERF_W-1:0] r_cyc_cnt;
  logic [PERF_W-1:0] r_ret_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc_cnt <= '0;
      r_ret_cnt <= '0;
    end else begin
      if (r_run && (r_state != ERR)) r_cyc_cnt <= r_cyc_cnt + PERF_W'(1);
      if (instr_done)                r_ret_cnt <= r_ret_cnt + PERF_W'(1);
    end
  end

  assign cyc_cnt = r_cyc_cnt;
  assign ret_cnt = r_ret_cnt;
`else
  localparam int c_unused_perf_w = PERF_W;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_mips_multicycle_ctrl
// Description : Self-checking bench for mips_multicycle_ctrl. A driver turns
//               each instruction (opcode plus memory latencies) into a list
//               of spec-level phases, pushes one expected output vector per
//               cycle into a scoreboard and drives the inputs; a monitor pops
//               and compares on every falling edge. Define MC_CTRL_PERF_EN to
//               also check cyc_cnt/ret_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_multicycle_ctrl;

  localparam int TO = 15;

  localparam logic [5:0] C_R    = 6'b000000;
  localparam logic [5:0] C_LW   = 6'b100011;
  localparam logic [5:0] C_LB   = 6'b100000;
  localparam logic [5:0] C_SW   = 6'b101011;
  localparam logic [5:0] C_BEQ  = 6'b000100;
  localparam logic [5:0] C_J    = 6'b000010;
  localparam logic [5:0] C_ADDI = 6'b001000;
  localparam logic [5:0] C_ORI  = 6'b001101;
  localparam logic [5:0] C_BAD  = 6'b111111;

  // Instruction phases as named by the behavioural description.
  localparam int PH_F = 0, PH_D = 1, PH_MA = 2, PH_MR = 3, PH_MW = 4;
  localparam int PH_MWB = 5, PH_EX = 6, PH_AW = 7, PH_BR = 8, PH_JP = 9;
  localparam int PH_IX = 10, PH_IW = 11, PH_ERR = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] op = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_wr, pc_wr_cond, iord, mem_rd, mem_wr, ir_wr, mem2reg;
  logic       reg_dst, reg_wr, wb_byte, alu_src_a, zext_imm, fault, instr_done;
  logic [1:0] alu_src_b, alu_op, pc_src, fault_code;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  mips_multicycle_ctrl #(
    .ALUOP_W     (2),
    .MEM_TIMEOUT (TO),
    .PERF_W      (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_wr      (pc_wr),
    .pc_wr_cond (pc_wr_cond),
    .iord       (iord),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .ir_wr      (ir_wr),
    .mem2reg    (mem2reg),
    .reg_dst    (reg_dst),
    .reg_wr     (reg_wr),
    .wb_byte    (wb_byte),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .zext_imm   (zext_imm),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .fault      (fault),
    .fault_code (fault_code),
    .instr_done (instr_done)
`ifdef MC_CTRL_PERF_EN
    ,
    .cyc_cnt    (cyc_cnt),
    .ret_cnt    (ret_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_wr;
    logic       pc_wr_cond;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wr;
    logic       mem2reg;
    logic       reg_dst;
    logic       reg_wr;
    logic       wb_byte;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zext_imm;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       fault;
    logic [1:0] fault_code;
    logic       instr_done;
  } sig_t;

  typedef struct {
    sig_t s;
    int   cyc;
    int   ret;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc_m = 0;
  int   ret_m = 0;

  // ---------------- monitor ----------------
  exp_t m_e;
  sig_t m_act;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e   = exp_q.pop_front();
      m_act = {pc_wr, pc_wr_cond, iord, mem_rd, mem_wr, ir_wr, mem2reg, reg_dst,
               reg_wr, wb_byte, alu_src_a, alu_src_b, zext_imm, alu_op, pc_src,
               fault, fault_code, instr_done};
      n_chk++;
      if (m_act !== m_e.s) begin
        n_fail++;
        $display("FAIL strobes @%0t: got %h required %h", $time, m_act, m_e.s);
      end
`ifdef MC_CTRL_PERF_EN
      n_chk++;
      if (cyc_cnt !== 32'(m_e.cyc)) begin
        n_fail++;
        $display("FAIL cyc_cnt @%0t: got %0d required %0d", $time, cyc_cnt, m_e.cyc);
      end
      n_chk++;
      if (ret_cnt !== 32'(m_e.ret)) begin
        n_fail++;
        $display("FAIL ret_cnt @%0t: got %0d required %0d", $time, ret_cnt, m_e.ret);
      end
`endif
    end
  end

  // ---------------- reference model ----------------
  function automatic sig_t expect_phase(input int ph, input logic rdy,
                                        input logic [5:0] opv, input logic [1:0] code);
    sig_t e;
    e = '0;
    case (ph)
      PH_F:   begin e.mem_rd = 1; e.alu_src_b = 2'd1; e.ir_wr = rdy; e.pc_wr = rdy; end
      PH_D:   e.alu_src_b = 2'd3;
      PH_MA:  begin e.alu_src_a = 1; e.alu_src_b = 2'd2; end
      PH_MR:  begin e.mem_rd = 1; e.iord = 1; end
      PH_MW:  begin e.mem_wr = 1; e.iord = 1; e.instr_done = rdy; end
      PH_MWB: begin e.reg_wr = 1; e.mem2reg = 1; e.wb_byte = (opv == C_LB); e.instr_done = 1; end
      PH_EX:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      PH_AW:  begin e.reg_wr = 1; e.reg_dst = 1; e.instr_done = 1; end
      PH_BR:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_wr_cond = 1; e.pc_src = 2'd1;
                    e.instr_done = 1; end
      PH_JP:  begin e.pc_wr = 1; e.pc_src = 2'd2; e.instr_done = 1; end
      PH_IX:  begin e.alu_src_a = 1; e.alu_src_b = 2'd2;
                    e.alu_op = (opv == C_ORI) ? 2'b11 : 2'b00; e.zext_imm = (opv == C_ORI); end
      PH_IW:  begin e.reg_wr = 1; e.instr_done = 1; end
      PH_ERR: begin e.fault = 1; e.fault_code = code; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic bit is_legal(input logic [5:0] v);
    return v == C_R || v == C_LW || v == C_LB || v == C_SW || v == C_BEQ ||
           v == C_J || v == C_ADDI || v == C_ORI;
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, publish the expected response, advance.
  task automatic step(input sig_t s, input logic rdy, input logic [5:0] opv, input bit counts);
    exp_t e;
    mem_ready = rdy;
    op        = opv;
    zero      = 1'($urandom);
    e.s   = s;
    e.cyc = cyc_m;
    e.ret = ret_m;
    exp_q.push_back(e);
    if (counts) cyc_m++;
    if (s.instr_done) ret_m++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n_low);
    rst_n = 1'b0;
    cyc_m = 0;
    ret_m = 0;
    for (int i = 0; i < n_low; i++) step('0, 1'($urandom), 6'($urandom), 1'b0);
    rst_n = 1'b1;
    // Run starts only on the edge after release.
    step('0, 1'($urandom), 6'($urandom), 1'b0);
  endtask

  task automatic play_err(input logic [1:0] code, input int n);
    for (int i = 0; i < n; i++)
      step(expect_phase(PH_ERR, 1'b0, 6'd0, code), 1'($urandom), 6'($urandom), 1'b0);
  endtask

  task automatic run_instr(input logic [5:0] opv, input int lat_f, input int lat_m,
                           input int abort_at, output logic [1:0] code, output bit aborted);
    int   ph_q[$];
    logic rdy_q[$];
    int   mem_ph;
    int   tail_ph;
    code    = 2'b00;
    aborted = 1'b0;
    mem_ph  = -1;
    tail_ph = -1;
    for (int i = 0; i < lat_f && i <= TO; i++) begin ph_q.push_back(PH_F); rdy_q.push_back(1'b0); end
    if (lat_f > TO) code = 2'b10;
    else begin
      ph_q.push_back(PH_F); rdy_q.push_back(1'b1);
      ph_q.push_back(PH_D); rdy_q.push_back(1'b0);
      case (opv)
        C_LW, C_LB: begin ph_q.push_back(PH_MA); rdy_q.push_back(1'b0); mem_ph = PH_MR; tail_ph = PH_MWB; end
        C_SW:       begin ph_q.push_back(PH_MA); rdy_q.push_back(1'b0); mem_ph = PH_MW; end
        C_R:        begin ph_q.push_back(PH_EX); rdy_q.push_back(1'b0); tail_ph = PH_AW; end
        C_BEQ:      tail_ph = PH_BR;
        C_J:        tail_ph = PH_JP;
        C_ADDI, C_ORI: begin ph_q.push_back(PH_IX); rdy_q.push_back(1'b0); tail_ph = PH_IW; end
        default:    code = 2'b01;
      endcase
      if (mem_ph >= 0) begin
        for (int i = 0; i < lat_m && i <= TO; i++) begin ph_q.push_back(mem_ph); rdy_q.push_back(1'b0); end
        if (lat_m > TO) code = 2'b10;
        else begin ph_q.push_back(mem_ph); rdy_q.push_back(1'b1); end
      end
      if (tail_ph >= 0 && code == 2'b00) begin ph_q.push_back(tail_ph); rdy_q.push_back(1'b0); end
    end
    for (int i = 0; i < ph_q.size(); i++) begin
      if (i == abort_at) begin
        aborted = 1'b1;
        break;
      end
      step(expect_phase(ph_q[i], rdy_q[i], opv, 2'b00), rdy_q[i],
           (ph_q[i] == PH_F) ? 6'($urandom) : opv, 1'b1);
    end
  endtask

  task automatic issue(input logic [5:0] opv, input int lat_f, input int lat_m, input int abort_at);
    logic [1:0] code;
    bit         ab;
    run_instr(opv, lat_f, lat_m, abort_at, code, ab);
    if (ab) do_reset($urandom_range(1, 3));
    else if (code != 2'b00) begin
      play_err(code, $urandom_range(2, 5));
      do_reset($urandom_range(1, 3));
    end
  endtask

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 19);
    if (r < 15)      return $urandom_range(0, 3);
    else if (r < 17) return TO - 1;
    else if (r < 19) return TO;
    else             return $urandom_range(TO + 1, TO + 3);
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] tbl [8];
    logic [5:0] v;
    int         r;
    tbl = '{C_R, C_LW, C_LB, C_SW, C_BEQ, C_J, C_ADDI, C_ORI};
    r = $urandom_range(0, 16);
    if (r < 16) return tbl[r % 8];
    v = 6'($urandom);
    while (is_legal(v)) v = 6'($urandom);
    return v;
  endfunction

  initial begin
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);
    issue(C_LW,   0, 0, -1);
    issue(C_R,    0, 0, -1);
    issue(C_BEQ,  0, 0, -1);
    issue(C_SW,   0, 3, -1);
    issue(C_LB,   0, 0, -1);
    issue(C_ADDI, 1, 0, -1);
    issue(C_ORI,  0, 0, -1);
    issue(C_J,    2, 0, -1);
    issue(C_LW,   TO, TO, -1);       // completion in the timeout cycle
    issue(C_SW,   TO - 1, TO, -1);
    issue(C_ADDI, TO + 4, 0, -1);    // fetch timeout
    issue(C_LB,   0, TO + 1, -1);    // read timeout
    issue(C_BAD,  0, 0, -1);         // illegal opcode
    issue(C_SW,   1, 3, 5);          // reset while mem_wr is pending
    issue(C_LW,   0, 0, 4);          // reset just before write-back
    for (int n = 0; n < 150; n++) begin
      issue(pick_op(), pick_lat(), pick_lat(),
            ($urandom_range(0, 19) == 0) ? $urandom_range(0, 6) : -1);
    end
    issue(C_J, 0, 0, -1);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
